// File: rtl/mac_feeder.sv
// Frame buffer and sequencer feeding a MAC accumulator: fill, stream, wait for rdy, hand back result.
// Optional build macro MAC_FEEDER_RELU_EN clamps negative results to zero at capture.
module mac_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int S1_NUM = 8,
    parameter int WAIT_MAX = 16,
    localparam int MAC_OUT_WIDTH = DATA_WIDTH*2+S1_NUM-1,
    localparam int AW = $clog2(S1_NUM)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic signed [DATA_WIDTH-1:0]    in_data,
    output logic                            in_ready,
    input  logic                            w_we,
    input  logic [AW-1:0]                   w_addr,
    input  logic signed [DATA_WIDTH-1:0]    w_data,
    output logic                            w_err,
    output logic signed [DATA_WIDTH-1:0]    mac_inp,
    output logic signed [DATA_WIDTH-1:0]    mac_weight,
    output logic                            mac_en,
    input  logic signed [MAC_OUT_WIDTH-1:0] mac_out,
    input  logic                            mac_rdy,
    output logic                            res_valid,
    output logic signed [MAC_OUT_WIDTH-1:0] res_data,
    input  logic                            res_ready,
    output logic                            timeout
);
    localparam int WW = $clog2(WAIT_MAX+1);
    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [AW-1:0]                   cnt_q, cnt_d, nxt;
    logic [WW-1:0]                   wait_q, wait_d;
    logic signed [DATA_WIDTH-1:0]    samp_q [S1_NUM];
    logic signed [DATA_WIDTH-1:0]    w_q [S1_NUM];
    logic                            mac_en_q, mac_en_d;
    logic signed [DATA_WIDTH-1:0]    mac_inp_q, mac_inp_d, mac_weight_q, mac_weight_d;
    logic                            res_valid_q, res_valid_d;
    logic signed [MAC_OUT_WIDTH-1:0] res_data_q, res_data_d;
    logic                            w_err_q, w_err_d;
    logic                            timeout_q, timeout_d;
    logic                            accept, w_ok;

    function automatic logic signed [MAC_OUT_WIDTH-1:0] capture(input logic signed [MAC_OUT_WIDTH-1:0] v);
`ifdef MAC_FEEDER_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign in_ready = (state_q == S_FILL);
    assign accept   = in_valid && in_ready;
    // Weights are frozen while a frame streams so every product uses one coherent set.
    assign w_ok     = w_we && (state_q != S_STREAM) && (int'(w_addr) < S1_NUM);
    assign nxt      = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        mac_en_d     = 1'b0;
        mac_inp_d    = '0;
        mac_weight_d = '0;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        timeout_d    = 1'b0;
        w_err_d      = w_we && !w_ok;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (cnt_q == AW'(S1_NUM-1)) begin
                        cnt_d        = '0;
                        state_d      = S_STREAM;
                        mac_en_d     = 1'b1;
                        mac_inp_d    = samp_q[0];
                        // A same-edge write to slot 0 must already be visible on the first pair.
                        mac_weight_d = (w_ok && w_addr == '0) ? w_data : w_q[0];
                    end else begin
                        cnt_d = nxt;
                    end
                end
            end
            S_STREAM: begin
                if (cnt_q == AW'(S1_NUM-1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    wait_d  = '0;
                end else begin
                    cnt_d        = nxt;
                    mac_en_d     = 1'b1;
                    mac_inp_d    = samp_q[nxt];
                    mac_weight_d = w_q[nxt];
                end
            end
            S_WAIT: begin
                if (mac_rdy) begin
                    res_data_d  = capture(mac_out);
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (wait_q == WW'(WAIT_MAX-1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FILL;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FILL;
            cnt_q        <= '0;
            wait_q       <= '0;
            mac_en_q     <= 1'b0;
            mac_inp_q    <= '0;
            mac_weight_q <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            w_err_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            mac_en_q     <= mac_en_d;
            mac_inp_q    <= mac_inp_d;
            mac_weight_q <= mac_weight_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            w_err_q      <= w_err_d;
            timeout_q    <= timeout_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < S1_NUM; i++) begin
                samp_q[i] <= '0;
                w_q[i]    <= '0;
            end
        end else begin
            if (accept) samp_q[cnt_q] <= in_data;
            if (w_ok) w_q[w_addr] <= w_data;
        end
    end

    assign mac_en     = mac_en_q;
    assign mac_inp    = mac_inp_q;
    assign mac_weight = mac_weight_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign w_err      = w_err_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_mac_feeder.sv
// Scoreboard bench for mac_feeder with a behavioural MAC accumulator model.
module tb_mac_feeder;
    localparam int DW  = 8;
    localparam int SN  = 4;
    localparam int WM  = 16;
    localparam int MOW = DW*2+SN-1;
    localparam int AW  = $clog2(SN);

    typedef struct {
        logic signed [DW-1:0] inp;
        logic signed [DW-1:0] wt;
    } pair_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic signed [DW-1:0]  in_data = '0;
    logic                  in_ready;
    logic                  w_we = 1'b0;
    logic [AW-1:0]         w_addr = '0;
    logic signed [DW-1:0]  w_data = '0;
    logic                  w_err;
    logic signed [DW-1:0]  mac_inp, mac_weight;
    logic                  mac_en;
    logic signed [MOW-1:0] mac_out;
    logic                  mac_rdy;
    logic                  res_valid;
    logic signed [MOW-1:0] res_data;
    logic                  res_ready = 1'b0;
    logic                  timeout;

    int vectors = 0;
    int miscompares = 0;
    int wm [SN];
    int samp [SN];
    pair_t pair_q [$];
    logic signed [MOW-1:0] res_q [$];

    bit rdy_on = 1'b1;
    bit ovr_en = 1'b0;
    logic signed [MOW-1:0] ovr_val = '0;

    mac_feeder #(.DATA_WIDTH(DW), .S1_NUM(SN), .WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_err(w_err),
        .mac_inp(mac_inp), .mac_weight(mac_weight), .mac_en(mac_en),
        .mac_out(mac_out), .mac_rdy(mac_rdy),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Behavioural accumulator: sums enabled products, pulses rdy one cycle after enable ends.
    logic signed [MOW-1:0] acc, ext_i, ext_w;
    logic en_prev, pend;
    assign ext_i = mac_inp;
    assign ext_w = mac_weight;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0; en_prev <= 1'b0; pend <= 1'b0; mac_rdy <= 1'b0; mac_out <= '0;
        end else begin
            en_prev <= mac_en;
            mac_rdy <= 1'b0;
            if (mac_en) acc <= acc + ext_i * ext_w;
            if (en_prev && !mac_en) begin
                if (rdy_on) pend <= 1'b1;
                else acc <= '0;
            end else if (pend) begin
                mac_rdy <= 1'b1;
                mac_out <= ovr_en ? ovr_val : acc;
                acc     <= '0;
                pend    <= 1'b0;
            end
        end
    end

    function automatic logic signed [MOW-1:0] exp_res(input int v);
`ifdef MAC_FEEDER_RELU_EN
        return (v < 0) ? '0 : MOW'(v);
`else
        return MOW'(v);
`endif
    endfunction

    task automatic write_w(input int a, input int d);
        @(negedge clk);
        w_we = 1'b1; w_addr = AW'(a); w_data = DW'(d);
        wm[a] = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic drive_frame(input bit push_res, input bit sim_we, input int sim_addr, input int sim_data);
        int sum;
        if (sim_we) wm[sim_addr] = sim_data;
        sum = 0;
        for (int k = 0; k < SN; k++) begin
            pair_t p;
            p.inp = DW'(samp[k]);
            p.wt  = DW'(wm[k]);
            pair_q.push_back(p);
            sum += samp[k] * wm[k];
        end
        if (push_res) res_q.push_back(exp_res(sum));
        for (int k = 0; k < SN; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(samp[k]);
            if (sim_we && k == SN-1) begin
                w_we = 1'b1; w_addr = AW'(sim_addr); w_data = DW'(sim_data);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (mac_rdy !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_result;
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (mac_en !== 1'b0) begin miscompares++; $display("FAIL reset_mac_en got %b want 0", mac_en); end
        vectors++; if (mac_inp !== '0) begin miscompares++; $display("FAIL reset_mac_inp got %0d want 0", mac_inp); end
        vectors++; if (mac_weight !== '0) begin miscompares++; $display("FAIL reset_mac_weight got %0d want 0", mac_weight); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (res_data !== '0) begin miscompares++; $display("FAIL reset_res_data got %0d want 0", res_data); end
        vectors++; if (w_err !== 1'b0) begin miscompares++; $display("FAIL reset_w_err got %b want 0", w_err); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", timeout); end
        reset = 1'b0;
        for (int i = 0; i < SN; i++) wm[i] = 0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        pair_t p;
        logic signed [MOW-1:0] e;
        int n;
        for (int i = 0; i < SN; i++) write_w(i, i + 1);
        samp = '{1, 1, 1, 1};
        drive_frame(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < SN; k++) begin
            if (k > 0) @(negedge clk);
            p = pair_q.pop_front();
            vectors++;
            if (mac_en !== 1'b1 || mac_inp !== p.inp || mac_weight !== p.wt) begin
                miscompares++;
                $display("FAIL basic_pair k=%0d got en=%b inp=%0d wt=%0d want en=1 inp=%0d wt=%0d", k, mac_en, mac_inp, mac_weight, p.inp, p.wt);
            end
        end
        @(negedge clk);
        vectors++;
        if (mac_en !== 1'b0 || mac_inp !== '0 || mac_weight !== '0) begin
            miscompares++;
            $display("FAIL basic_stream_end got en=%b inp=%0d wt=%0d want 0 0 0", mac_en, mac_inp, mac_weight);
        end
        wait_rdy(n);
        @(negedge clk);
        e = res_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            miscompares++;
            $display("FAIL basic_result got valid=%b data=%0d want valid=1 data=%0d", res_valid, res_data, e);
        end
        release_result;
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_handshake got valid=%b in_ready=%b want 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_wide_stall;
        logic signed [MOW-1:0] e;
        int n;
        for (int i = 0; i < SN; i++) write_w(i, -128);
        samp = '{-128, -128, -128, -128};
        drive_frame(1'b1, 1'b0, 0, 0);
        pair_q.delete();
        wait_rdy(n);
        @(negedge clk);
        e = res_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (res_valid !== 1'b1 || res_data !== e || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL wide_hold i=%0d got valid=%b data=%0d in_ready=%b want 1 %0d 0", i, res_valid, res_data, in_ready, e);
            end
            @(negedge clk);
        end
        release_result;
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_handshake got valid=%b in_ready=%b want 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_w_err;
        pair_t p;
        logic signed [MOW-1:0] e;
        int n;
        for (int i = 0; i < SN; i++) write_w(i, i + 2);
        samp = '{1, -1, 2, -2};
        drive_frame(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < SN; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin
                w_we = 1'b1; w_addr = '0; w_data = 8'sd7;
            end
            if (k == 2) begin
                w_we = 1'b0;
                vectors++;
                if (w_err !== 1'b1) begin miscompares++; $display("FAIL werr_pulse got %b want 1", w_err); end
            end
            if (k == 3) begin
                vectors++;
                if (w_err !== 1'b0) begin miscompares++; $display("FAIL werr_single got %b want 0", w_err); end
            end
            p = pair_q.pop_front();
            vectors++;
            if (mac_en !== 1'b1 || mac_inp !== p.inp || mac_weight !== p.wt) begin
                miscompares++;
                $display("FAIL werr_pair k=%0d got en=%b inp=%0d wt=%0d want en=1 inp=%0d wt=%0d", k, mac_en, mac_inp, mac_weight, p.inp, p.wt);
            end
        end
        wait_rdy(n);
        @(negedge clk);
        e = res_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            miscompares++;
            $display("FAIL werr_result got valid=%b data=%0d want 1 %0d", res_valid, res_data, e);
        end
        release_result;
        samp = '{1, 0, 0, 0};
        drive_frame(1'b1, 1'b0, 0, 0);
        p = pair_q.pop_front();
        pair_q.delete();
        vectors++;
        if (mac_en !== 1'b1 || mac_weight !== p.wt) begin
            miscompares++;
            $display("FAIL werr_w0_kept got en=%b wt=%0d want 1 %0d", mac_en, mac_weight, p.wt);
        end
        wait_rdy(n);
        @(negedge clk);
        e = res_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            miscompares++;
            $display("FAIL werr_next_result got valid=%b data=%0d want 1 %0d", res_valid, res_data, e);
        end
        release_result;
    endtask

    task automatic test_simul_write;
        pair_t p;
        logic signed [MOW-1:0] e;
        int n;
        samp = '{1, 0, 0, 0};
        drive_frame(1'b1, 1'b1, 0, 9);
        for (int k = 0; k < SN; k++) begin
            if (k > 0) @(negedge clk);
            p = pair_q.pop_front();
            vectors++;
            if (mac_en !== 1'b1 || mac_inp !== p.inp || mac_weight !== p.wt) begin
                miscompares++;
                $display("FAIL simul_pair k=%0d got en=%b inp=%0d wt=%0d want en=1 inp=%0d wt=%0d", k, mac_en, mac_inp, mac_weight, p.inp, p.wt);
            end
        end
        wait_rdy(n);
        @(negedge clk);
        e = res_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            miscompares++;
            $display("FAIL simul_result got valid=%b data=%0d want 1 %0d", res_valid, res_data, e);
        end
        release_result;
    endtask

    task automatic test_timeout;
        int n;
        rdy_on = 1'b0;
        samp = '{1, 1, 1, 1};
        drive_frame(1'b0, 1'b0, 0, 0);
        pair_q.delete();
        n = 0;
        res_ready = 1'b1;
        while (timeout !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        res_ready = 1'b0;
        vectors++;
        if (n != 20) begin miscompares++; $display("FAIL timeout_latency got %0d want 20", n); end
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_state got valid=%b in_ready=%b want 0 1", res_valid, in_ready);
        end
        @(negedge clk);
        vectors++;
        if (timeout !== 1'b0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_after got timeout=%b in_ready=%b valid=%b want 0 1 0", timeout, in_ready, res_valid);
        end
        rdy_on = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic signed [MOW-1:0] e;
        int n;
        samp = '{1, 1, 1, 1};
        drive_frame(1'b0, 1'b0, 0, 0);
        pair_q.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (mac_en !== 1'b0 || mac_inp !== '0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset got en=%b inp=%0d in_ready=%b valid=%b want 0 0 1 0", mac_en, mac_inp, in_ready, res_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < SN; i++) wm[i] = 0;
        for (int i = 0; i < SN; i++) write_w(i, 4 - i);
        samp = '{5, -6, 7, 8};
        drive_frame(1'b1, 1'b0, 0, 0);
        pair_q.delete();
        wait_rdy(n);
        @(negedge clk);
        e = res_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            miscompares++;
            $display("FAIL midreset_next got valid=%b data=%0d want 1 %0d", res_valid, res_data, e);
        end
        release_result;
    endtask

    task automatic test_relu;
        logic signed [MOW-1:0] e;
        int n;
        ovr_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ovr_val = (r == 0) ? -19'sd5 : 19'sd9;
            samp = '{1, 2, 3, 4};
            drive_frame(1'b0, 1'b0, 0, 0);
            pair_q.delete();
            res_q.push_back(exp_res((r == 0) ? -5 : 9));
            wait_rdy(n);
            @(negedge clk);
            e = res_q.pop_front();
            vectors++;
            if (res_valid !== 1'b1 || res_data !== e) begin
                miscompares++;
                $display("FAIL relu_capture r=%0d got valid=%b data=%0d want 1 %0d", r, res_valid, res_data, e);
            end
            release_result;
        end
        ovr_en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wide_stall;
        test_w_err;
        test_simul_write;
        test_timeout;
        test_reset_mid;
        test_relu;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got timeout want completion");
        $fatal(1);
    end
endmodule
